cube: RTL

//  Sequential 8-bit integer cube: result = a*a*a, 24-bit exact, no overflow (255^3 < 2^24).

---
 rtl/cube_pkg.sv | 9 +
 rtl/cube_mult.sv | 38 +++
 rtl/cube.sv | 78 +++++++
 3 files changed

// File: rtl/cube_pkg.sv
// cube_pkg: shared widths, FSM encodings and phase selectors for the cube unit
package cube_pkg;
  localparam int IN_W = 8;
  localparam int OUT_W = 24;
  typedef enum logic [2:0] {IDLE, MUL_START, MUL_GAP, MUL_WAIT, ACCUM} state_t;
  localparam logic [1:0] PHASE_SQ = 2'd0;
  localparam logic [1:0] PHASE_LO = 2'd1;
  localparam logic [1:0] PHASE_HI = 2'd2;
endpackage

// File: rtl/cube_mult.sv
// mult: 8x8 -> 16 shift-add multiplier, busy rises the cycle after start
module mult (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic [15:0] product
);
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [3:0]  cnt;
  // one partial product per cycle; product is final when busy drops
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      product <= '0;
    end else if (!busy) begin
      if (start) begin
        busy <= 1'b1;
        mcand <= {8'b0, a};
        mplier <= b;
        cnt <= 4'd8;
        product <= '0;
      end
    end else begin
      product <= mplier[0] ? product + mcand : product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt - 4'd1;
      busy <= cnt != 4'd1;
    end
  end
endmodule

// File: rtl/cube.sv
// cube: sequential a^3 via three passes through the shared 8x8 multiplier
module cube
  import cube_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IN_W-1:0]  a,
  output logic             busy,
  output logic [OUT_W-1:0] result
);
  state_t state, state_n;
  logic [1:0]       phase;
  logic [IN_W-1:0]  x, mult_a, mult_b;
  logic [15:0]      sq, p, mult_p;
  logic [OUT_W-1:0] acc;
  logic             mult_start, mult_busy;
  mult u_mult (
    .clk(clk),
    .reset(reset),
    .start(mult_start),
    .a(mult_a),
    .b(mult_b),
    .busy(mult_busy),
    .product(mult_p)
  );
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // next state: three multiply rounds, the gap lets mult busy become valid
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? MUL_START : IDLE;
      MUL_START: state_n = MUL_GAP;
      MUL_GAP:   state_n = MUL_WAIT;
      MUL_WAIT:  state_n = mult_busy ? MUL_WAIT : ACCUM;
      ACCUM:     state_n = phase == PHASE_HI ? IDLE : MUL_START;
      default:   state_n = IDLE;
    endcase
  end
  // datapath: x*x -> sq, then x*sq split into low and high byte products
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= PHASE_SQ;
      x <= '0;
      sq <= '0;
      p <= '0;
      acc <= '0;
      mult_a <= '0;
      mult_b <= '0;
      mult_start <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x <= a;
          acc <= '0;
          phase <= PHASE_SQ;
        end
        MUL_START: begin
          mult_start <= 1'b1;
          mult_a <= x;
          mult_b <= phase == PHASE_SQ ? x : phase == PHASE_LO ? sq[7:0] : sq[15:8];
        end
        MUL_GAP: mult_start <= 1'b0;
        MUL_WAIT: if (!mult_busy) p <= mult_p;
        ACCUM: begin
          if (phase == PHASE_SQ) sq <= p;
          if (phase == PHASE_LO) acc <= acc + {8'b0, p};
          if (phase == PHASE_HI) result <= acc + {p, 8'b0};
          else phase <= phase + 2'd1;
        end
        default: mult_start <= 1'b0;
      endcase
    end
  end
endmodule
